id_ex_operand_stage: RTL and testbench
======================================

// Module: id_ex_operand_stage
// PURPOSE
//  ID/EX pipeline register plus EX-stage operand forwarding and select logic; sits directly upstream of the ALU.
//  Latches decoded ID fields each cycle.
//  Resolves RAW hazards from the EX/MEM and MEM/WB stages.
//  Drives ALUCode/A/B to the ALU, plus store data and write-back control to EX/MEM.
// PARAMETERS
//  DATA_W      32        datapath width
//  RADDR_W     5         register-file address width
//  NOP_CODE    5'b00000  ALUCode loaded on reset/flush (alu_add)
// PORTS
//  clk               in   1        clock, rising edge
//  reset_n           in   1        asynchronous reset, active-low
//  stall             in   1        hold ID/EX contents
//  flush             in   1        load bubble into ID/EX
//  ALUCode_id        in   5        decoded ALU operation
//  ALUSrcA_id        in   1        1: A = zero-extended shamt (shifts)
//  ALUSrcB_id        in   1        1: B = imm
//  RegDst_id         in   1        1: dest = rd, 0: dest = rt
//  RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id  in 1 each  control bits
//  RsData_id, RtData_id in DATA_W  register-file read data
//  Imm_id            in   DATA_W   extended immediate
//  Shamt_id          in   5        shift amount
//  RsAddr_id, RtAddr_id, RdAddr_id  in  RADDR_W  register numbers
//  RegWrite_mem      in   1        EX/MEM will write back
//  RegWriteAddr_mem  in   RADDR_W  EX/MEM destination
//  ALUResult_mem     in   DATA_W   EX/MEM ALU result
//  RegWrite_wb       in   1        MEM/WB will write back
//  RegWriteAddr_wb   in   RADDR_W  MEM/WB destination
//  RegWriteData_wb   in   DATA_W   MEM/WB write-back data
//  ALUCode_ex        out  5        to ALU ALUCode
//  ALU_A, ALU_B      out  DATA_W   to ALU A, B
//  MemWriteData_ex   out  DATA_W   forwarded rt value, for stores
//  RegWriteAddr_ex   out  RADDR_W  selected destination
//  RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex  out 1 each  registered control
//  valid_ex          out  1        0 when EX holds a bubble
// BEHAVIOUR
//  Reset (reset_n=0, async): all ID/EX registers 0, ALUCode_ex=NOP_CODE, valid_ex=0.
//   With regs at 0 and no forwarding from r0: ALU_A=ALU_B=0, RegWriteAddr_ex=0.
//  Register update on each rising clk, priority order:
//   1. flush=1 (wins over stall): load a bubble.
//      Bubble = all control bits 0, ALUCode=NOP_CODE, valid=0, data/addr fields 0.
//   2. stall=1: hold all registers.
//   3. otherwise: capture all *_id inputs, valid=1.
//  Latency: *_id sampled at edge N, visible on *_ex/ALU_* after edge N.
//   No other registers in the path.
//  RegWriteAddr_ex = RegDst ? Rd : Rt, from the registered fields.
//  Forwarding is combinational, same cycle, evaluated per source (rs, rt):
//   - MEM hit = RegWrite_mem and RegWriteAddr_mem != 0 and RegWriteAddr_mem == src.
//   - WB hit  = RegWrite_wb  and RegWriteAddr_wb  != 0 and RegWriteAddr_wb  == src.
//   - fwd value = MEM hit ? ALUResult_mem : WB hit ? RegWriteData_wb : registered data.
//   - MEM beats WB when both hit. Register 0 is never forwarded.
//  ALU_A = ALUSrcA ? {27'b0, Shamt} : fwd_rs.
//  ALU_B = ALUSrcB ? Imm : fwd_rt.
//  MemWriteData_ex = fwd_rt, independent of ALUSrcB.
//  Bubble: forwarding still active, but outputs are don't-care while valid_ex=0.
//   RegWrite_ex and MemWrite_ex must be 0 in a bubble.
//  reset_n asserted mid-stall or mid-flush: reset wins immediately.
//  No arithmetic in this block. All widths pass through unchanged; no truncation.
// TESTING
//  T1 reset: reset_n=0 at any phase.
//   -> all outputs 0, ALUCode_ex=5'b00000, valid_ex=0, without waiting for a clk edge.
//  T2 pass-through: add r3,r1,r2 with RsData=5, RtData=7, no hazards.
//   -> next cycle ALU_A=5, ALU_B=7, RegWriteAddr_ex=3, valid_ex=1.
//  T3 double forward: ID/EX rs=r4; EX/MEM writes r4=0x11; MEM/WB writes r4=0x22.
//   -> ALU_A=0x11. Drop RegWrite_mem -> ALU_A=0x22.
//  T4 r0 guard: EX/MEM writes r0=0xFFFF_FFFF, rt=r0, RtData=0.
//   -> ALU_B=0 and MemWriteData_ex=0.
//  T5 shift/imm select: sra, ALUSrcA=1, Shamt=4, rt fwd from WB=0x8000_0000.
//   -> ALU_A=4, ALU_B=0x8000_0000.
//   Then ALUSrcB=1, Imm=0xFFFF_FFFC, MemWrite=1.
//   -> ALU_B=0xFFFF_FFFC, MemWriteData_ex=fwd rt.
//  T6 stall/flush: stall=1 for 2 cycles -> outputs held.
//   Then stall=1 and flush=1 together -> bubble: valid_ex=0, RegWrite_ex=0, MemWrite_ex=0.
//   Then both low -> new ID fields appear one cycle later.

Source files
------------

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage RAW forwarding and ALU operand selection.
// Feeds ALUCode/A/B to the ALU and store data plus write-back control to EX/MEM.
module id_ex_operand_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned RADDR_W  = 5,
    parameter logic [4:0]  NOP_CODE = 5'b00000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               flush,
    input  logic [4:0]         ALUCode_id,
    input  logic               ALUSrcA_id,
    input  logic               ALUSrcB_id,
    input  logic               RegDst_id,
    input  logic               RegWrite_id,
    input  logic               MemRead_id,
    input  logic               MemWrite_id,
    input  logic               MemtoReg_id,
    input  logic [DATA_W-1:0]  RsData_id,
    input  logic [DATA_W-1:0]  RtData_id,
    input  logic [DATA_W-1:0]  Imm_id,
    input  logic [4:0]         Shamt_id,
    input  logic [RADDR_W-1:0] RsAddr_id,
    input  logic [RADDR_W-1:0] RtAddr_id,
    input  logic [RADDR_W-1:0] RdAddr_id,
    input  logic               RegWrite_mem,
    input  logic [RADDR_W-1:0] RegWriteAddr_mem,
    input  logic [DATA_W-1:0]  ALUResult_mem,
    input  logic               RegWrite_wb,
    input  logic [RADDR_W-1:0] RegWriteAddr_wb,
    input  logic [DATA_W-1:0]  RegWriteData_wb,
    output logic [4:0]         ALUCode_ex,
    output logic [DATA_W-1:0]  ALU_A,
    output logic [DATA_W-1:0]  ALU_B,
    output logic [DATA_W-1:0]  MemWriteData_ex,
    output logic [RADDR_W-1:0] RegWriteAddr_ex,
    output logic               RegWrite_ex,
    output logic               MemRead_ex,
    output logic               MemWrite_ex,
    output logic               MemtoReg_ex,
    output logic               valid_ex
);

    localparam int unsigned SHAMT_W = 5;

    typedef struct packed {
        logic [4:0]         alu_code;
        logic               alu_src_a;
        logic               alu_src_b;
        logic               reg_dst;
        logic               reg_write;
        logic               mem_read;
        logic               mem_write;
        logic               mem_to_reg;
        logic [DATA_W-1:0]  rs_data;
        logic [DATA_W-1:0]  rt_data;
        logic [DATA_W-1:0]  imm;
        logic [SHAMT_W-1:0] shamt;
        logic [RADDR_W-1:0] rs_addr;
        logic [RADDR_W-1:0] rt_addr;
        logic [RADDR_W-1:0] rd_addr;
        logic               valid;
    } id_ex_t;

    id_ex_t id_fields;
    id_ex_t bubble;
    id_ex_t ex_q;

    logic [DATA_W-1:0] fwd_rs;
    logic [DATA_W-1:0] fwd_rt;

    always_comb begin
        bubble          = '0;
        bubble.alu_code = NOP_CODE;
    end

    always_comb begin
        id_fields            = '0;
        id_fields.alu_code   = ALUCode_id;
        id_fields.alu_src_a  = ALUSrcA_id;
        id_fields.alu_src_b  = ALUSrcB_id;
        id_fields.reg_dst    = RegDst_id;
        id_fields.reg_write  = RegWrite_id;
        id_fields.mem_read   = MemRead_id;
        id_fields.mem_write  = MemWrite_id;
        id_fields.mem_to_reg = MemtoReg_id;
        id_fields.rs_data    = RsData_id;
        id_fields.rt_data    = RtData_id;
        id_fields.imm        = Imm_id;
        id_fields.shamt      = Shamt_id;
        id_fields.rs_addr    = RsAddr_id;
        id_fields.rt_addr    = RtAddr_id;
        id_fields.rd_addr    = RdAddr_id;
        id_fields.valid      = 1'b1;
    end

    // Flush outranks stall so a squashed instruction never lingers in EX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q <= bubble;
        end else if (flush) begin
            ex_q <= bubble;
        end else if (!stall) begin
            ex_q <= id_fields;
        end
    end

    function automatic logic [DATA_W-1:0] forward(
        input logic [RADDR_W-1:0] src,
        input logic [DATA_W-1:0]  reg_val,
        input logic               mem_we,
        input logic [RADDR_W-1:0] mem_addr,
        input logic [DATA_W-1:0]  mem_val,
        input logic               wb_we,
        input logic [RADDR_W-1:0] wb_addr,
        input logic [DATA_W-1:0]  wb_val
    );
        logic mem_hit;
        logic wb_hit;
        mem_hit = mem_we && (mem_addr != '0) && (mem_addr == src);
        wb_hit  = wb_we  && (wb_addr  != '0) && (wb_addr  == src);
        if (mem_hit)
            return mem_val;
        else if (wb_hit)
            return wb_val;
        else
            return reg_val;
    endfunction

    always_comb begin
        fwd_rs = forward(ex_q.rs_addr, ex_q.rs_data,
                         RegWrite_mem, RegWriteAddr_mem, ALUResult_mem,
                         RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb);
        fwd_rt = forward(ex_q.rt_addr, ex_q.rt_data,
                         RegWrite_mem, RegWriteAddr_mem, ALUResult_mem,
                         RegWrite_wb, RegWriteAddr_wb, RegWriteData_wb);
    end

    always_comb begin
        ALUCode_ex      = ex_q.alu_code;
        ALU_A           = ex_q.alu_src_a ? {{(DATA_W-SHAMT_W){1'b0}}, ex_q.shamt} : fwd_rs;
        ALU_B           = ex_q.alu_src_b ? ex_q.imm : fwd_rt;
        MemWriteData_ex = fwd_rt;
        RegWriteAddr_ex = ex_q.reg_dst ? ex_q.rd_addr : ex_q.rt_addr;
        RegWrite_ex     = ex_q.reg_write;
        MemRead_ex      = ex_q.mem_read;
        MemWrite_ex     = ex_q.mem_write;
        MemtoReg_ex     = ex_q.mem_to_reg;
        valid_ex        = ex_q.valid;
    end

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: directed hazard scenarios plus
// randomized traffic checked against a behavioural pipeline-slot model.
module tb_id_ex_operand_stage;

    typedef struct {
        logic [4:0]  alucode;
        logic        srca, srcb, regdst, regwrite, memread, memwrite, memtoreg;
        logic [31:0] rs_data, rt_data, imm;
        logic [4:0]  shamt, rs, rt, rd;
    } id_t;

    typedef struct {
        logic        rw_mem;
        logic [4:0]  wa_mem;
        logic [31:0] res_mem;
        logic        rw_wb;
        logic [4:0]  wa_wb;
        logic [31:0] wd_wb;
    } fwd_t;

    typedef struct {
        int          tag;
        logic [4:0]  alucode;
        logic [31:0] a, b, mwd;
        logic [4:0]  wa;
        logic        rw, mr, mw, mtr, valid;
    } exp_t;

    logic        clk, reset_n, stall, flush;
    logic [4:0]  ALUCode_id, Shamt_id, RsAddr_id, RtAddr_id, RdAddr_id;
    logic        ALUSrcA_id, ALUSrcB_id, RegDst_id, RegWrite_id, MemRead_id, MemWrite_id, MemtoReg_id;
    logic [31:0] RsData_id, RtData_id, Imm_id;
    logic        RegWrite_mem, RegWrite_wb;
    logic [4:0]  RegWriteAddr_mem, RegWriteAddr_wb;
    logic [31:0] ALUResult_mem, RegWriteData_wb;
    logic [4:0]  ALUCode_ex, RegWriteAddr_ex;
    logic [31:0] ALU_A, ALU_B, MemWriteData_ex;
    logic        RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex, valid_ex;

    id_ex_operand_stage #(.DATA_W(32), .RADDR_W(5), .NOP_CODE(5'b00000)) dut (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .ALUCode_id(ALUCode_id), .ALUSrcA_id(ALUSrcA_id), .ALUSrcB_id(ALUSrcB_id),
        .RegDst_id(RegDst_id), .RegWrite_id(RegWrite_id), .MemRead_id(MemRead_id),
        .MemWrite_id(MemWrite_id), .MemtoReg_id(MemtoReg_id),
        .RsData_id(RsData_id), .RtData_id(RtData_id), .Imm_id(Imm_id), .Shamt_id(Shamt_id),
        .RsAddr_id(RsAddr_id), .RtAddr_id(RtAddr_id), .RdAddr_id(RdAddr_id),
        .RegWrite_mem(RegWrite_mem), .RegWriteAddr_mem(RegWriteAddr_mem), .ALUResult_mem(ALUResult_mem),
        .RegWrite_wb(RegWrite_wb), .RegWriteAddr_wb(RegWriteAddr_wb), .RegWriteData_wb(RegWriteData_wb),
        .ALUCode_ex(ALUCode_ex), .ALU_A(ALU_A), .ALU_B(ALU_B), .MemWriteData_ex(MemWriteData_ex),
        .RegWriteAddr_ex(RegWriteAddr_ex), .RegWrite_ex(RegWrite_ex), .MemRead_ex(MemRead_ex),
        .MemWrite_ex(MemWrite_ex), .MemtoReg_ex(MemtoReg_ex), .valid_ex(valid_ex)
    );

    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    // Reference model: the instruction currently sitting in EX, or none.
    id_t m_slot;
    bit  m_valid;
    int  tag_ctr = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(string name, int tag, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s (item %0d): got %h, expected %h", name, tag, act, exp);
        end
    endfunction

    function automatic id_t empty_id();
        id_t z;
        z = '{alucode: 5'd0, srca: 1'b0, srcb: 1'b0, regdst: 1'b0, regwrite: 1'b0,
              memread: 1'b0, memwrite: 1'b0, memtoreg: 1'b0,
              rs_data: 32'd0, rt_data: 32'd0, imm: 32'd0,
              shamt: 5'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0};
        return z;
    endfunction

    function automatic fwd_t no_fwd();
        fwd_t f;
        f = '{rw_mem: 1'b0, wa_mem: 5'd0, res_mem: 32'd0, rw_wb: 1'b0, wa_wb: 5'd0, wd_wb: 32'd0};
        return f;
    endfunction

    // Latest producer of a register wins; r0 always reads as the file's value.
    function automatic logic [31:0] operand(logic [4:0] r, logic [31:0] file_val, fwd_t f);
        if (r == 5'd0) return file_val;
        if (f.rw_mem && f.wa_mem == r) return f.res_mem;
        if (f.rw_wb && f.wa_wb == r) return f.wd_wb;
        return file_val;
    endfunction

    function automatic exp_t predict(fwd_t f);
        exp_t e;
        logic [31:0] rt_val;
        rt_val    = operand(m_slot.rt, m_slot.rt_data, f);
        e.tag     = tag_ctr;
        e.valid   = m_valid;
        e.alucode = m_slot.alucode;
        e.a       = m_slot.srca ? 32'(m_slot.shamt) : operand(m_slot.rs, m_slot.rs_data, f);
        e.b       = m_slot.srcb ? m_slot.imm : rt_val;
        e.mwd     = rt_val;
        e.wa      = m_slot.regdst ? m_slot.rd : m_slot.rt;
        e.rw      = m_slot.regwrite;
        e.mr      = m_slot.memread;
        e.mw      = m_slot.memwrite;
        e.mtr     = m_slot.memtoreg;
        return e;
    endfunction

    task automatic drive_id(id_t d);
        ALUCode_id = d.alucode; ALUSrcA_id = d.srca; ALUSrcB_id = d.srcb; RegDst_id = d.regdst;
        RegWrite_id = d.regwrite; MemRead_id = d.memread; MemWrite_id = d.memwrite; MemtoReg_id = d.memtoreg;
        RsData_id = d.rs_data; RtData_id = d.rt_data; Imm_id = d.imm; Shamt_id = d.shamt;
        RsAddr_id = d.rs; RtAddr_id = d.rt; RdAddr_id = d.rd;
    endtask

    task automatic drive_fwd(fwd_t f);
        RegWrite_mem = f.rw_mem; RegWriteAddr_mem = f.wa_mem; ALUResult_mem = f.res_mem;
        RegWrite_wb = f.rw_wb; RegWriteAddr_wb = f.wa_wb; RegWriteData_wb = f.wd_wb;
    endtask

    // One clock: present ID fields and controls, clock them in, then present
    // the downstream stage state and queue what EX should show this cycle.
    task automatic step(id_t d, bit st, bit fl, fwd_t f);
        drive_id(d);
        stall = st;
        flush = fl;
        @(posedge clk);
        if (fl) begin
            m_slot  = empty_id();
            m_valid = 1'b0;
        end else if (!st) begin
            m_slot  = d;
            m_valid = 1'b1;
        end
        #1;
        drive_fwd(f);
        tag_ctr++;
        sb.push_back(predict(f));
    endtask

    task automatic check_reset_state(int tag);
        chk("rst_alucode", tag, 32'(ALUCode_ex), 32'd0);
        chk("rst_alu_a", tag, ALU_A, 32'd0);
        chk("rst_alu_b", tag, ALU_B, 32'd0);
        chk("rst_mwd", tag, MemWriteData_ex, 32'd0);
        chk("rst_wa", tag, 32'(RegWriteAddr_ex), 32'd0);
        chk("rst_ctrl", tag, {28'd0, RegWrite_ex, MemRead_ex, MemWrite_ex, MemtoReg_ex}, 32'd0);
        chk("rst_valid", tag, 32'(valid_ex), 32'd0);
    endtask

    // Monitor: every negedge with an outstanding expectation, compare EX outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("valid", e.tag, 32'(valid_ex), 32'(e.valid));
                chk("regwrite", e.tag, 32'(RegWrite_ex), 32'(e.rw));
                chk("memwrite", e.tag, 32'(MemWrite_ex), 32'(e.mw));
                if (e.valid) begin
                    chk("alucode", e.tag, 32'(ALUCode_ex), 32'(e.alucode));
                    chk("alu_a", e.tag, ALU_A, e.a);
                    chk("alu_b", e.tag, ALU_B, e.b);
                    chk("mem_wdata", e.tag, MemWriteData_ex, e.mwd);
                    chk("wr_addr", e.tag, 32'(RegWriteAddr_ex), 32'(e.wa));
                    chk("memread", e.tag, 32'(MemRead_ex), 32'(e.mr));
                    chk("memtoreg", e.tag, 32'(MemtoReg_ex), 32'(e.mtr));
                end else begin
                    chk("bubble_alucode", e.tag, 32'(ALUCode_ex), 32'd0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "time limit");
    end

    function automatic id_t rand_id();
        id_t d;
        d.alucode = 5'($urandom); d.srca = 1'($urandom); d.srcb = 1'($urandom);
        d.regdst = 1'($urandom); d.regwrite = 1'($urandom); d.memread = 1'($urandom);
        d.memwrite = 1'($urandom); d.memtoreg = 1'($urandom);
        d.rs_data = $urandom; d.rt_data = $urandom; d.imm = $urandom;
        d.shamt = 5'($urandom);
        d.rs = 5'($urandom_range(0, 7)); d.rt = 5'($urandom_range(0, 7)); d.rd = 5'($urandom);
        return d;
    endfunction

    function automatic fwd_t rand_fwd();
        fwd_t f;
        f.rw_mem = 1'($urandom); f.wa_mem = 5'($urandom_range(0, 7)); f.res_mem = $urandom;
        f.rw_wb = 1'($urandom); f.wa_wb = 5'($urandom_range(0, 7)); f.wd_wb = $urandom;
        return f;
    endfunction

    task automatic random_run(int n);
        for (int i = 0; i < n; i++)
            step(rand_id(), ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10), rand_fwd());
    endtask

    initial begin
        id_t  d, x, y;
        fwd_t f;
        reset_n = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_id(empty_id());
        drive_fwd(no_fwd());
        m_slot = empty_id();
        m_valid = 1'b0;

        // Reset asserted between edges takes effect without a clock.
        #3 reset_n = 1'b0;
        #1 check_reset_state(-1);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // add r3,r1,r2, no hazards
        d = empty_id(); d.regdst = 1'b1; d.regwrite = 1'b1;
        d.rs = 5'd1; d.rt = 5'd2; d.rd = 5'd3; d.rs_data = 32'd5; d.rt_data = 32'd7;
        step(d, 0, 0, no_fwd());

        // rs=r4 produced by both MEM and WB; then MEM stops writing
        d = empty_id(); d.rs = 5'd4; d.rt = 5'd5; d.rs_data = 32'h99; d.regwrite = 1'b1;
        f = no_fwd(); f.rw_mem = 1'b1; f.wa_mem = 5'd4; f.res_mem = 32'h11;
        f.rw_wb = 1'b1; f.wa_wb = 5'd4; f.wd_wb = 32'h22;
        step(d, 0, 0, f);
        f.rw_mem = 1'b0;
        step(d, 1, 0, f);

        // r0 must never be forwarded
        d = empty_id(); d.rt = 5'd0; d.rt_data = 32'd0; d.memwrite = 1'b1;
        f = no_fwd(); f.rw_mem = 1'b1; f.wa_mem = 5'd0; f.res_mem = 32'hFFFF_FFFF;
        f.rw_wb = 1'b1; f.wa_wb = 5'd0; f.wd_wb = 32'hFFFF_FFFF;
        step(d, 0, 0, f);

        // sra with shamt source, rt from WB; then immediate B with store
        d = empty_id(); d.alucode = 5'b01011; d.srca = 1'b1; d.shamt = 5'd4;
        d.rs = 5'd9; d.rs_data = 32'h1357; d.rt = 5'd6; d.rt_data = 32'h1234; d.regwrite = 1'b1;
        f = no_fwd(); f.rw_wb = 1'b1; f.wa_wb = 5'd6; f.wd_wb = 32'h8000_0000;
        step(d, 0, 0, f);
        d.srcb = 1'b1; d.imm = 32'hFFFF_FFFC; d.memwrite = 1'b1; d.regwrite = 1'b0;
        step(d, 0, 0, f);

        // stall holds, stall+flush bubbles, release shows new fields
        x = rand_id(); x.regwrite = 1'b1; x.memwrite = 1'b1;
        y = rand_id(); y.regwrite = 1'b1; y.memwrite = 1'b1;
        f = rand_fwd();
        step(x, 0, 0, f);
        step(y, 1, 0, f);
        step(y, 1, 0, f);
        step(y, 1, 1, f);
        step(y, 0, 0, f);

        random_run(300);

        // Reset in the middle of a stall+flush cycle, away from any edge.
        stall = 1'b1; flush = 1'b1;
        drive_fwd(rand_fwd());
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1 check_reset_state(-2);
        m_slot = empty_id();
        m_valid = 1'b0;
        #1 reset_n = 1'b1;

        random_run(200);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", -3, 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
